evil_bullet_pool: RTL and testbench

Enemy-side counterpart of the player bullet. It manages a pool of NUM_BULLETS enemy bullets that spawn at the enemy and travel left (−x) toward the player.
Fire requests are rate-limited by a cooldown counter. Each bullet is checked for collision against the player, taking squat and defend into account. Outputs feed the renderer and the player HP/score logic.

---
 rtl/game_pkg.sv | 15 +
 rtl/evil_bullet_slot.sv | 110 +++++++++++
 rtl/evil_bullet_pool.sv | 98 +++++++++
 tb/tb_evil_bullet_pool.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game geometry and timing constants (half-extents in pixels, steps per update).
package game_pkg;

  localparam int BULLET_X       = 8;
  localparam int BULLET_Y       = 4;
  localparam int BULLET_STEP_X  = 4;
  localparam int PLAYER_X       = 16;
  localparam int PLAYER_Y       = 32;
  localparam int SQUAT_PLAYER_Y = 16;
  localparam int MAP_X          = 640;

  localparam int BULLET_STEP_Y       = 2;
  localparam int ENEMY_FIRE_COOLDOWN = 30;

endpackage

// File: rtl/evil_bullet_slot.sv
// One enemy bullet: leftward motion, player collision and off-screen retirement.
// With EVIL_BULLET_AIM_EN defined, y homes toward the player y latched at spawn.
module evil_bullet_slot
  import game_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spawn_i,
  input  logic signed [10:0] spawn_x_i,
  input  logic signed [9:0]  spawn_y_i,
  input  logic signed [10:0] x_player_i,
  input  logic signed [9:0]  y_player_i,
  input  logic              is_q_i,
  input  logic              defend_i,
  output logic signed [10:0] x_o,
  output logic signed [9:0]  y_o,
  output logic              is_e_o,
  output logic              hit_o,
  output logic              blocked_o
);

  localparam logic signed [11:0] Bx  = 12'(BULLET_X);
  localparam logic signed [11:0] By  = 12'(BULLET_Y);
  localparam logic signed [11:0] Sx  = 12'(BULLET_STEP_X);
  localparam logic signed [11:0] Px  = 12'(PLAYER_X);
  localparam logic signed [11:0] Py  = 12'(PLAYER_Y);
  localparam logic signed [11:0] Sqy = 12'(SQUAT_PLAYER_Y);

  logic signed [10:0] x_q, x_d;
  logic signed [9:0]  y_q, y_d;
  logic               ise_q, ise_d;
  logic signed [11:0] x_w, y_w, y_s, xp, yp, half_h;
  logic               hit_raw, off_scr;

`ifdef EVIL_BULLET_AIM_EN
  localparam logic signed [11:0] Sy = 12'(BULLET_STEP_Y);
  logic signed [9:0]  tgt_q, tgt_d;
  logic signed [11:0] dy;
`endif

  always_comb begin
    x_w    = {x_q[10], x_q} - Sx;
    y_s    = {{2{y_q[9]}}, y_q};
    xp     = {x_player_i[10], x_player_i};
    yp     = {{2{y_player_i[9]}}, y_player_i};
    half_h = is_q_i ? Sqy : Py;
`ifdef EVIL_BULLET_AIM_EN
    dy = {{2{tgt_q[9]}}, tgt_q} - y_s;
    if (dy <= Sy && dy >= -Sy) begin
      y_w = {{2{tgt_q[9]}}, tgt_q};
    end else if (dy > 0) begin
      y_w = y_s + Sy;
    end else begin
      y_w = y_s - Sy;
    end
`else
    y_w = y_s;
`endif
    hit_raw = ise_q
            && ((x_w - Bx) < (xp + Px))
            && ((x_w + Bx) > (xp - Px))
            && !(((y_w - By) > (yp + half_h)) || ((y_w + By) < (yp - half_h)));
    off_scr   = x_w < Bx;
    hit_o     = hit_raw & ~defend_i;
    blocked_o = hit_raw & defend_i;

    x_d   = x_q;
    y_d   = y_q;
    ise_d = ise_q;
`ifdef EVIL_BULLET_AIM_EN
    tgt_d = tgt_q;
`endif
    // Spawn only targets free slots, so it never competes with a live update.
    if (spawn_i) begin
      x_d   = spawn_x_i;
      y_d   = spawn_y_i;
      ise_d = 1'b1;
`ifdef EVIL_BULLET_AIM_EN
      tgt_d = y_player_i;
`endif
    end else if (ise_q) begin
      x_d   = x_w[10:0];
      y_d   = y_w[9:0];
      ise_d = !(hit_raw || off_scr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      y_q   <= '0;
      ise_q <= 1'b0;
`ifdef EVIL_BULLET_AIM_EN
      tgt_q <= '0;
`endif
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      ise_q <= ise_d;
`ifdef EVIL_BULLET_AIM_EN
      tgt_q <= tgt_d;
`endif
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign is_e_o = ise_q;

endmodule

// File: rtl/evil_bullet_pool.sv
// Pool of enemy bullets with lowest-free slot allocation, fire cooldown and hit aggregation.
// Optional aimed bullets are enabled by defining EVIL_BULLET_AIM_EN.
module evil_bullet_pool
  import game_pkg::*;
#(
  parameter int unsigned NUM_BULLETS   = 4,
  parameter int unsigned FIRE_COOLDOWN = ENEMY_FIRE_COOLDOWN
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              attack,
  input  logic signed [10:0]                xEnemy,
  input  logic signed [9:0]                 yEnemy,
  input  logic signed [10:0]                xPlayer,
  input  logic signed [9:0]                 yPlayer,
  input  logic                              isQ,
  input  logic                              defend,
  output logic [NUM_BULLETS*11-1:0]         x,
  output logic [NUM_BULLETS*10-1:0]         y,
  output logic [NUM_BULLETS-1:0]            isE,
  output logic                              isHit,
  output logic [$clog2(NUM_BULLETS+1)-1:0]  hitCount,
  output logic                              isBlocked,
  output logic                              cdBusy
);

  localparam int unsigned CdW = (FIRE_COOLDOWN == 0) ? 1 : $clog2(FIRE_COOLDOWN + 1);
  localparam int unsigned HcW = $clog2(NUM_BULLETS + 1);

  logic [CdW-1:0]         cd_q, cd_d;
  logic [NUM_BULLETS-1:0] free_sel, spawn_vec, hit_vec, blk_vec;
  logic                   any_free, accept;
  logic signed [10:0]     spawn_x;

  assign spawn_x = xEnemy - 11'(PLAYER_X + BULLET_X);

  // Allocation looks only at registered flags; a slot freed this cycle waits one cycle.
  always_comb begin
    free_sel = '0;
    any_free = 1'b0;
    for (int i = 0; i < int'(NUM_BULLETS); i++) begin
      if (!isE[i] && !any_free) begin
        free_sel[i] = 1'b1;
        any_free    = 1'b1;
      end
    end
    accept    = attack && (cd_q == '0) && any_free;
    spawn_vec = accept ? free_sel : '0;
  end

  always_comb begin
    cd_d = cd_q;
    if (accept) begin
      cd_d = CdW'(FIRE_COOLDOWN);
    end else if (cd_q != '0) begin
      cd_d = cd_q - CdW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd_q <= '0;
    end else begin
      cd_q <= cd_d;
    end
  end

  assign cdBusy = (cd_q != '0);

  for (genvar i = 0; i < int'(NUM_BULLETS); i++) begin : g_slot
    evil_bullet_slot u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .spawn_i    (spawn_vec[i]),
      .spawn_x_i  (spawn_x),
      .spawn_y_i  (yEnemy),
      .x_player_i (xPlayer),
      .y_player_i (yPlayer),
      .is_q_i     (isQ),
      .defend_i   (defend),
      .x_o        (x[11*i +: 11]),
      .y_o        (y[10*i +: 10]),
      .is_e_o     (isE[i]),
      .hit_o      (hit_vec[i]),
      .blocked_o  (blk_vec[i])
    );
  end

  always_comb begin
    hitCount = '0;
    for (int i = 0; i < int'(NUM_BULLETS); i++) begin
      hitCount = hitCount + HcW'(hit_vec[i]);
    end
    isHit     = |hit_vec;
    isBlocked = |blk_vec;
  end

endmodule

// File: tb/tb_evil_bullet_pool.sv
// Directed bench for evil_bullet_pool: spawn, cooldown, hit/block, squat dodge, async reset.
module tb_evil_bullet_pool;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               attack = 1'b0;
  logic               isQ = 1'b0;
  logic               defend = 1'b0;
  logic signed [10:0] xEnemy = 11'sd500;
  logic signed [10:0] xPlayer = 11'sd440;
  logic signed [9:0]  yEnemy = 10'sd200;
  logic signed [9:0]  yPlayer = -10'sd400;
  logic [43:0]        x;
  logic [39:0]        y;
  logic [3:0]         isE;
  logic               isHit, isBlocked, cdBusy;
  logic [2:0]         hitCount;
  int                 checks = 0;
  int                 errors = 0;

  always #5 clk = ~clk;

  evil_bullet_pool #(
    .NUM_BULLETS   (4),
    .FIRE_COOLDOWN (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .attack    (attack),
    .xEnemy    (xEnemy),
    .yEnemy    (yEnemy),
    .xPlayer   (xPlayer),
    .yPlayer   (yPlayer),
    .isQ       (isQ),
    .defend    (defend),
    .x         (x),
    .y         (y),
    .isE       (isE),
    .isHit     (isHit),
    .hitCount  (hitCount),
    .isBlocked (isBlocked),
    .cdBusy    (cdBusy)
  );

  function automatic logic [10:0] sx(input int i);
    return x[11*i +: 11];
  endfunction

  function automatic logic [9:0] sy(input int i);
    return y[10*i +: 10];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    attack  = 1'b0;
    isQ     = 1'b0;
    defend  = 1'b0;
    xEnemy  = 11'sd500;
    yEnemy  = 10'sd200;
    xPlayer = 11'sd440;
    yPlayer = -10'sd400;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++; if (isE !== 4'b0000) begin errors++; $display("FAIL reset_isE got %b exp 0000", isE); end
    checks++; if (x !== 44'd0) begin errors++; $display("FAIL reset_x got %h exp 0", x); end
    checks++; if (y !== 40'd0) begin errors++; $display("FAIL reset_y got %h exp 0", y); end
    checks++; if (cdBusy !== 1'b0) begin errors++; $display("FAIL reset_cdBusy got %b exp 0", cdBusy); end
    checks++; if (isHit !== 1'b0) begin errors++; $display("FAIL reset_isHit got %b exp 0", isHit); end
    checks++; if (hitCount !== 3'd0) begin errors++; $display("FAIL reset_hitCount got %0d exp 0", hitCount); end
    checks++; if (isBlocked !== 1'b0) begin errors++; $display("FAIL reset_isBlocked got %b exp 0", isBlocked); end
    rst_n = 1'b1;
  endtask

  task automatic test_spawn();
    do_reset();
    attack = 1'b1;
    tick();
    attack = 1'b0;
    checks++; if (isE !== 4'b0001) begin errors++; $display("FAIL spawn_isE got %b exp 0001", isE); end
    checks++; if (sx(0) !== 11'd476) begin errors++; $display("FAIL spawn_x got %0d exp 476", sx(0)); end
    checks++; if (sy(0) !== 10'd200) begin errors++; $display("FAIL spawn_y got %0d exp 200", sy(0)); end
    checks++; if (cdBusy !== 1'b1) begin errors++; $display("FAIL spawn_cdBusy got %b exp 1", cdBusy); end
    repeat (4) tick();
    checks++; if (cdBusy !== 1'b1) begin errors++; $display("FAIL cd_4 got %b exp 1", cdBusy); end
    tick();
    checks++; if (cdBusy !== 1'b0) begin errors++; $display("FAIL cd_5 got %b exp 0", cdBusy); end
    checks++; if (sx(0) !== 11'd456) begin errors++; $display("FAIL move_x got %0d exp 456", sx(0)); end
  endtask

  task automatic test_cooldown();
    logic [3:0] exp_e;
    int         cnt;
    do_reset();
    attack = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      cnt   = 1 + int'(c >= 6) + int'(c >= 12) + int'(c >= 18);
      exp_e = 4'((1 << cnt) - 1);
      checks++;
      if (isE !== exp_e) begin
        errors++; $display("FAIL cd_isE c=%0d got %b exp %b", c, isE, exp_e);
      end
      if (c == 18) begin
        checks++; if (sx(0) !== 11'd404) begin errors++; $display("FAIL cd_x0 got %0d exp 404", sx(0)); end
        checks++; if (sx(3) !== 11'd476) begin errors++; $display("FAIL cd_x3 got %0d exp 476", sx(3)); end
      end
      if (c == 22) begin
        checks++; if (cdBusy !== 1'b1) begin errors++; $display("FAIL cd_busy22 got %b exp 1", cdBusy); end
      end
      if (c == 23) begin
        checks++; if (cdBusy !== 1'b0) begin errors++; $display("FAIL cd_busy23 got %b exp 0", cdBusy); end
      end
    end
    checks++; if (cdBusy !== 1'b0) begin errors++; $display("FAIL cd_full_idle got %b exp 0", cdBusy); end
    attack = 1'b0;
  endtask

  task automatic test_hit();
    do_reset();
    yPlayer = 10'sd200;
    attack  = 1'b1;
    tick();
    attack = 1'b0;
    repeat (2) begin
      tick();
      checks++; if (isHit !== 1'b0) begin errors++; $display("FAIL hit_early got %b exp 0", isHit); end
    end
    tick();
    checks++; if (sx(0) !== 11'd464) begin errors++; $display("FAIL hit_x got %0d exp 464", sx(0)); end
    checks++; if (isHit !== 1'b1) begin errors++; $display("FAIL hit_pulse got %b exp 1", isHit); end
    checks++; if (hitCount !== 3'd1) begin errors++; $display("FAIL hit_count got %0d exp 1", hitCount); end
    checks++; if (isBlocked !== 1'b0) begin errors++; $display("FAIL hit_blk got %b exp 0", isBlocked); end
    tick();
    checks++; if (isE !== 4'b0000) begin errors++; $display("FAIL hit_clear got %b exp 0000", isE); end
    checks++; if (isHit !== 1'b0) begin errors++; $display("FAIL hit_single got %b exp 0", isHit); end
  endtask

  task automatic test_blocked();
    do_reset();
    yPlayer = 10'sd200;
    defend  = 1'b1;
    attack  = 1'b1;
    tick();
    attack = 1'b0;
    repeat (2) begin
      tick();
      checks++; if (isBlocked !== 1'b0) begin errors++; $display("FAIL blk_early got %b exp 0", isBlocked); end
    end
    tick();
    checks++; if (isBlocked !== 1'b1) begin errors++; $display("FAIL blk_pulse got %b exp 1", isBlocked); end
    checks++; if (isHit !== 1'b0) begin errors++; $display("FAIL blk_isHit got %b exp 0", isHit); end
    checks++; if (hitCount !== 3'd0) begin errors++; $display("FAIL blk_count got %0d exp 0", hitCount); end
    tick();
    checks++; if (isE !== 4'b0000) begin errors++; $display("FAIL blk_clear got %b exp 0000", isE); end
    defend = 1'b0;
  endtask

  task automatic test_squat_dodge();
    logic seen;
    do_reset();
    isQ     = 1'b1;
    yPlayer = 10'sd200;
    yEnemy  = 10'sd179;
    seen    = 1'b0;
    for (int k = 0; k <= 118; k++) begin
      attack = (k <= 6);
      tick();
      if (isHit || isBlocked) seen = 1'b1;
      if (k == 117) begin
        checks++; if (isE !== 4'b0011) begin errors++; $display("FAIL sq_live got %b exp 0011", isE); end
        checks++; if (sx(0) !== 11'd8) begin errors++; $display("FAIL sq_xlast got %0d exp 8", sx(0)); end
      end
      if (k == 118) begin
        checks++; if (isE !== 4'b0010) begin errors++; $display("FAIL sq_exit got %b exp 0010", isE); end
      end
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL sq_nohit got %b exp 0", seen); end
    attack = 1'b1;
    tick();
    attack = 1'b0;
    checks++; if (isE !== 4'b0011) begin errors++; $display("FAIL sq_reuse got %b exp 0011", isE); end
    checks++; if (sx(0) !== 11'd476) begin errors++; $display("FAIL sq_reuse_x got %0d exp 476", sx(0)); end
    checks++; if (sy(0) !== 10'd179) begin errors++; $display("FAIL sq_reuse_y got %0d exp 179", sy(0)); end
    checks++; if (sx(1) !== 11'd24) begin errors++; $display("FAIL sq_x1 got %0d exp 24", sx(1)); end
    isQ = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    attack = 1'b1;
    repeat (13) tick();
    attack = 1'b0;
    checks++; if (isE !== 4'b0111) begin errors++; $display("FAIL mid_pre got %b exp 0111", isE); end
    checks++; if (cdBusy !== 1'b1) begin errors++; $display("FAIL mid_pre_cd got %b exp 1", cdBusy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (isE !== 4'b0000) begin errors++; $display("FAIL mid_isE got %b exp 0000", isE); end
    checks++; if (x !== 44'd0) begin errors++; $display("FAIL mid_x got %h exp 0", x); end
    checks++; if (y !== 40'd0) begin errors++; $display("FAIL mid_y got %h exp 0", y); end
    checks++; if (cdBusy !== 1'b0) begin errors++; $display("FAIL mid_cd got %b exp 0", cdBusy); end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_cooldown();
    test_hit();
    test_blocked();
    test_squat_dodge();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
